// File: rtl/fifo_wr_arbiter_if.sv
// Bus between four write requesters, the arbiter and the downstream FIFO.
// The arbiter uses the master modport because it drives the FIFO write port.
// The slave modport is the environment side: the requesters and the FIFO.
// Macro FIFO_WR_ARB_GRANT_CNT_EN adds the gnt_cnt grant-counter output.
interface fifo_wr_arbiter_if;
    logic [3:0]  req;
    logic [7:0]  din0;
    logic [7:0]  din1;
    logic [7:0]  din2;
    logic [7:0]  din3;
    logic [3:0]  gnt;
    logic        fifo_full;
    logic        fifo_wr_err;
    logic        fifo_we;
    logic [7:0]  fifo_din;
    logic        busy;
    logic        err;
`ifdef FIFO_WR_ARB_GRANT_CNT_EN
    logic [31:0] gnt_cnt;
`endif

    modport master (
        input  req, din0, din1, din2, din3, fifo_full, fifo_wr_err,
        output gnt, fifo_we, fifo_din, busy, err
`ifdef FIFO_WR_ARB_GRANT_CNT_EN
        , output gnt_cnt
`endif
    );

    modport slave (
        output req, din0, din1, din2, din3, fifo_full, fifo_wr_err,
        input  gnt, fifo_we, fifo_din, busy, err
`ifdef FIFO_WR_ARB_GRANT_CNT_EN
        , input gnt_cnt
`endif
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: four requesters share one 8-deep sync FIFO.
// Each grant issues a single registered write pulse, then waits one SETTLE
// cycle so that fifo_full reflects that write before the next arbitration.
// Macro FIFO_WR_ARB_GRANT_CNT_EN adds four 8-bit saturating grant counters
// on gnt_cnt (byte i belongs to requester i).
module fifo_wr_arbiter (
    input  logic              clk,
    input  logic              rst_n,
    fifo_wr_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  rr_ptr;
    logic [1:0]  rr_ptr_next;
    logic [1:0]  winner;
    logic        win_valid;
    logic [7:0]  din_sel;
    logic [3:0]  gnt_q;
    logic [3:0]  gnt_next;
    logic        we_q;
    logic        we_next;
    logic [7:0]  din_q;
    logic [7:0]  din_next;
    logic        err_q;

    // Pick the first requester at or after rr_ptr, wrapping 3 -> 0.
    always_comb begin
        winner    = rr_ptr;
        win_valid = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.req[rr_ptr + 2'(i)]) begin
                winner    = rr_ptr + 2'(i);
                win_valid = 1'b1;
            end
        end
    end

    // Data of the current winner, only used on the arbitration cycle.
    always_comb begin
        case (winner)
            2'd0:    din_sel = bus.din0;
            2'd1:    din_sel = bus.din1;
            2'd2:    din_sel = bus.din2;
            default: din_sel = bus.din3;
        endcase
    end

    // Next state and next registered outputs; fifo_full only matters in IDLE.
    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        gnt_next    = 4'b0000;
        we_next     = 1'b0;
        din_next    = din_q;
        case (state)
            IDLE: begin
                if (win_valid && !bus.fifo_full) begin
                    state_next  = ISSUE;
                    rr_ptr_next = winner + 2'd1;
                    gnt_next    = 4'b0001 << winner;
                    we_next     = 1'b1;
                    din_next    = din_sel;
                end
            end
            ISSUE:   state_next = SETTLE;
            SETTLE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, pointer and registered write port; reset also kills a live pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= 2'd0;
            gnt_q  <= 4'b0000;
            we_q   <= 1'b0;
            din_q  <= 8'h00;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
            gnt_q  <= gnt_next;
            we_q   <= we_next;
            din_q  <= din_next;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (bus.fifo_wr_err) begin
            err_q <= 1'b1;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.fifo_we  = we_q;
    assign bus.fifo_din = din_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state != IDLE);

`ifdef FIFO_WR_ARB_GRANT_CNT_EN
    logic [7:0] gnt_cnt_q [4];

    // Per-requester grant counters that stop at 0xFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                gnt_cnt_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (gnt_q[i] && gnt_cnt_q[i] != 8'hFF) begin
                    gnt_cnt_q[i] <= gnt_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign bus.gnt_cnt = {gnt_cnt_q[3], gnt_cnt_q[2], gnt_cnt_q[1], gnt_cnt_q[0]};
`endif
endmodule
